// File: rtl/score_fill_sequencer_if.sv
// Handshake bundle between the score-fill sequencer, the top-level control,
// the score-RAM write-index stage and the cell max unit.
interface score_fill_sequencer_if #(
  parameter int N       = 128,
  parameter int BitAddr = $clog2(N + 1)
);
  logic               start;
  logic               max_valid;
  logic               en_init;
  logic               hit;
  logic [BitAddr:0]   addr_init;
  logic signed [8:0]  data_init;
  logic               en_ins;
  logic [BitAddr:0]   i;
  logic [BitAddr:0]   j;
  logic               cell_req;
  logic               busy;
  logic               done;

  modport master (
    input  start, max_valid,
    output en_init, hit, addr_init, data_init, en_ins, i, j, cell_req, busy, done
  );

  modport slave (
    output start, max_valid,
    input  en_init, hit, addr_init, data_init, en_ins, i, j, cell_req, busy, done
  );
endinterface

// File: rtl/score_fill_sequencer.sv
// Control FSM for one Needleman-Wunsch score-matrix pass: gap-penalty init of
// row 0 / column 0, then a row-major sweep of interior cells via the max unit.
module score_fill_sequencer #(
  parameter int N       = 128,
  parameter int BitAddr = $clog2(N + 1),
  parameter int GAP     = -2
) (
  input  logic                   clk,
  input  logic                   rst,
  score_fill_sequencer_if.master bus
);
  localparam int KW = BitAddr + 1;
  localparam logic [BitAddr:0] K_LAST  = KW'(N);
  localparam logic [BitAddr:0] IJ_LAST = KW'(N - 1);
  localparam logic [BitAddr:0] IDX_0   = KW'(0);
  localparam logic [BitAddr:0] IDX_1   = KW'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT_ROW = 3'd1,
    INIT_COL = 3'd2,
    FILL_REQ = 3'd3,
    FILL_WR  = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t           state_r, state_nx;
  logic [BitAddr:0] k_r, k_nx, i_r, i_nx, j_r, j_nx;

  logic              en_init_r, en_init_nx;
  logic              hit_r, hit_nx;
  logic [BitAddr:0]  addr_r, addr_nx;
  logic signed [8:0] data_r, data_nx;
  logic              en_ins_r, en_ins_nx;
  logic [BitAddr:0]  i_out_r, i_out_nx, j_out_r, j_out_nx;
  logic              cell_req_r, cell_req_nx;
  logic              busy_r, busy_nx;
  logic              done_r, done_nx;

  // k*GAP at 32-bit signed width, clamped into the 9-bit score range.
  function automatic logic signed [8:0] sat_gap(input logic [BitAddr:0] k);
    logic signed [31:0] prod;
    prod = $signed(32'(k)) * GAP;
    if (prod > 32'sd255) begin
      sat_gap = 9'sd255;
    end else if (prod < -32'sd256) begin
      sat_gap = 9'sh100;
    end else begin
      sat_gap = $signed(prod[8:0]);
    end
  endfunction

  // State, counters and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      k_r        <= IDX_0;
      i_r        <= IDX_0;
      j_r        <= IDX_0;
      en_init_r  <= 1'b0;
      hit_r      <= 1'b0;
      addr_r     <= IDX_0;
      data_r     <= 9'sd0;
      en_ins_r   <= 1'b0;
      i_out_r    <= IDX_0;
      j_out_r    <= IDX_0;
      cell_req_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nx;
      k_r        <= k_nx;
      i_r        <= i_nx;
      j_r        <= j_nx;
      en_init_r  <= en_init_nx;
      hit_r      <= hit_nx;
      addr_r     <= addr_nx;
      data_r     <= data_nx;
      en_ins_r   <= en_ins_nx;
      i_out_r    <= i_out_nx;
      j_out_r    <= j_out_nx;
      cell_req_r <= cell_req_nx;
      busy_r     <= busy_nx;
      done_r     <= done_nx;
    end
  end

  // Next state and counter advance.
  always_comb begin
    state_nx = state_r;
    k_nx     = k_r;
    i_nx     = i_r;
    j_nx     = j_r;
    case (state_r)
      IDLE: begin
        k_nx = IDX_0;
        i_nx = IDX_0;
        j_nx = IDX_0;
        if (bus.start) state_nx = INIT_ROW;
        else           state_nx = IDLE;
      end
      INIT_ROW: begin
        if (k_r == K_LAST) begin
          state_nx = INIT_COL;
          k_nx     = IDX_1;
        end else begin
          k_nx = k_r + IDX_1;
        end
      end
      INIT_COL: begin
        if (k_r == K_LAST) begin
          state_nx = FILL_REQ;
          k_nx     = IDX_0;
          i_nx     = IDX_0;
          j_nx     = IDX_0;
        end else begin
          k_nx = k_r + IDX_1;
        end
      end
      FILL_REQ: begin
        if (bus.max_valid) state_nx = FILL_WR;
        else               state_nx = FILL_REQ;
      end
      FILL_WR: begin
        if (j_r == IJ_LAST) begin
          j_nx = IDX_0;
          if (i_r == IJ_LAST) begin
            i_nx     = IDX_0;
            state_nx = DONE;
          end else begin
            i_nx     = i_r + IDX_1;
            state_nx = FILL_REQ;
          end
        end else begin
          j_nx     = j_r + IDX_1;
          state_nx = FILL_REQ;
        end
      end
      DONE: begin
        state_nx = IDLE;
        k_nx     = IDX_0;
        i_nx     = IDX_0;
        j_nx     = IDX_0;
      end
      default: begin
        state_nx = IDLE;
        k_nx     = IDX_0;
        i_nx     = IDX_0;
        j_nx     = IDX_0;
      end
    endcase
  end

  // Outputs decoded from the upcoming state so the registers line up with it.
  always_comb begin
    en_init_nx  = 1'b0;
    hit_nx      = 1'b0;
    addr_nx     = IDX_0;
    data_nx     = 9'sd0;
    en_ins_nx   = 1'b0;
    i_out_nx    = IDX_0;
    j_out_nx    = IDX_0;
    cell_req_nx = 1'b0;
    busy_nx     = 1'b0;
    done_nx     = 1'b0;
    case (state_nx)
      INIT_ROW, INIT_COL: begin
        en_init_nx = 1'b1;
        hit_nx     = (state_nx == INIT_COL);
        addr_nx    = k_nx;
        data_nx    = sat_gap(k_nx);
        busy_nx    = 1'b1;
      end
      FILL_REQ: begin
        cell_req_nx = 1'b1;
        i_out_nx    = i_nx;
        j_out_nx    = j_nx;
        busy_nx     = 1'b1;
      end
      FILL_WR: begin
        en_ins_nx = 1'b1;
        i_out_nx  = i_nx;
        j_out_nx  = j_nx;
        busy_nx   = 1'b1;
      end
      DONE: begin
        done_nx = 1'b1;
      end
      IDLE: begin
        done_nx = 1'b0;
      end
      default: begin
        done_nx = 1'b0;
      end
    endcase
  end

  assign bus.en_init   = en_init_r;
  assign bus.hit       = hit_r;
  assign bus.addr_init = addr_r;
  assign bus.data_init = data_r;
  assign bus.en_ins    = en_ins_r;
  assign bus.i         = i_out_r;
  assign bus.j         = j_out_r;
  assign bus.cell_req  = cell_req_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
endmodule

// File: tb/tb_score_fill_sequencer.sv
// Randomised bench for score_fill_sequencer: a small-N instance checked cycle by
// cycle against a queue-based pass model, and a large-N instance for saturation.
module tb_score_fill_sequencer;
  localparam int NA = 4;
  localparam int GA = -2;
  localparam int NB = 128;
  localparam int GB = -3;
  localparam int WA = $clog2(NA + 1) + 1;
  localparam int WB = $clog2(NB + 1) + 1;
  localparam int LAT = 1 + (2 * NA + 1) + 2 * NA * NA;

  typedef struct {
    logic hit;
    int   addr;
    int   data;
  } init_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  score_fill_sequencer_if #(.N(NA)) bus_a ();
  score_fill_sequencer_if #(.N(NB)) bus_b ();

  score_fill_sequencer #(.N(NA), .GAP(GA)) dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
  score_fill_sequencer #(.N(NB), .GAP(GB)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int mv_mode = 0;
  int stall = 0;
  int req_run = 0;
  int ninit, ncell;
  bit start_req = 1'b0;
  bit restart_en = 1'b0;
  bit armed = 1'b0;
  bit running = 1'b0;
  bit prev_req = 1'b0, prev_mv = 1'b0, prev_ins = 1'b0;
  init_t exp_init[$];
  int exp_cell[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sat_ref(input int k, input int gap);
    int p;
    p = k * gap;
    if (p < -256) return -256;
    if (p > 255) return 255;
    return p;
  endfunction

  function automatic logic [31:0] pack_a();
    return {5'd0, bus_a.en_init, bus_a.hit, bus_a.addr_init, bus_a.data_init, bus_a.en_ins,
            bus_a.i, bus_a.j, bus_a.cell_req, bus_a.busy, bus_a.done};
  endfunction

  // Expected pass: row-0 writes, column-0 writes (corner once), then cells row-major.
  task automatic load_model();
    init_t e;
    exp_init.delete();
    exp_cell.delete();
    for (int k = 0; k <= NA; k++) begin
      e.hit = 1'b0; e.addr = k; e.data = sat_ref(k, GA);
      exp_init.push_back(e);
    end
    for (int k = 1; k <= NA; k++) begin
      e.hit = 1'b1; e.addr = k; e.data = sat_ref(k, GA);
      exp_init.push_back(e);
    end
    for (int c = 0; c < NA * NA; c++) exp_cell.push_back(c);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus driver for instance A: start pulses and max_valid patterns.
  initial begin
    bus_a.start = 1'b0;
    bus_a.max_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (start_req) begin
        bus_a.start = 1'b1;
        start_cyc = cyc;
        armed = 1'b1;
        start_req = 1'b0;
      end else begin
        bus_a.start = restart_en && bus_a.busy && ($urandom_range(0, 3) == 0);
      end
      case (mv_mode)
        1: bus_a.max_valid = ($urandom_range(0, 2) != 0);
        2: begin
          if (bus_a.cell_req && bus_a.i == WA'(1) && bus_a.j == WA'(2) && stall < 3) begin
            bus_a.max_valid = 1'b0;
            stall++;
          end else begin
            bus_a.max_valid = 1'b1;
          end
        end
        default: bus_a.max_valid = 1'b1;
      endcase
    end
  end

  // Cycle monitor for instance A against the pass model.
  initial begin
    init_t e;
    logic [WA-1:0] ci, cj;
    bit ins_exp, req_exp, done_exp;
    int c;
    forever begin
      @(negedge clk);
      if (armed && cyc == start_cyc + 1) begin
        running = 1'b1;
        armed = 1'b0;
      end
      ninit = exp_init.size();
      ncell = exp_cell.size();
      ins_exp  = running && ninit == 0 && prev_req && prev_mv;
      req_exp  = running && ninit == 0 && ncell > 0 && !ins_exp;
      done_exp = running && ninit == 0 && ncell == 0 && prev_ins;

      check_eq("excl", 32'(bus_a.en_init & bus_a.en_ins), 32'd0);
      check_eq("en_init", 32'(bus_a.en_init), 32'(running && ninit > 0));
      if (bus_a.en_init) begin
        if (ninit > 0) begin
          e = exp_init.pop_front();
          check_eq("init_hit", 32'(bus_a.hit), 32'(e.hit));
          check_eq("init_addr", 32'(bus_a.addr_init), 32'(e.addr));
          check_eq("init_data", 32'(int'(bus_a.data_init)), 32'(e.data));
        end
      end else begin
        check_eq("init_zero", {18'd0, bus_a.hit, bus_a.addr_init, bus_a.data_init}, 32'd0);
      end

      check_eq("en_ins", 32'(bus_a.en_ins), 32'(ins_exp));
      check_eq("cell_req", 32'(bus_a.cell_req), 32'(req_exp));
      if (bus_a.cell_req || bus_a.en_ins) begin
        c = (ncell > 0) ? exp_cell[0] : NA * NA;
        ci = WA'(c / NA);
        cj = WA'(c % NA);
        check_eq("cell_ij", 32'({bus_a.i, bus_a.j}), 32'({ci, cj}));
        if (bus_a.en_ins) begin
          if (mv_mode == 0) check_eq("req_len", 32'(req_run), 32'd1);
          if (mv_mode == 2) check_eq("req_len", 32'(req_run), (c == NA + 2) ? 32'd4 : 32'd1);
          if (ncell > 0) void'(exp_cell.pop_front());
          req_run = 0;
        end else begin
          req_run++;
        end
      end else begin
        check_eq("ij_zero", 32'({bus_a.i, bus_a.j}), 32'd0);
      end

      check_eq("busy", 32'(bus_a.busy), 32'(running && (ninit + ncell) > 0));
      check_eq("done", 32'(bus_a.done), 32'(done_exp));
      if (bus_a.done) begin
        done_cnt++;
        if (mv_mode == 0) check_eq("latency", 32'(cyc - start_cyc), 32'(LAT));
        if (mv_mode == 2) check_eq("latency", 32'(cyc - start_cyc), 32'(LAT + 3));
      end
      if (done_exp) running = 1'b0;
      prev_req = bus_a.cell_req;
      prev_mv  = bus_a.max_valid;
      prev_ins = bus_a.en_ins;
    end
  end

  task automatic run_pass(input int mode, input bit restart);
    int d0;
    mv_mode = mode;
    restart_en = restart;
    stall = 0;
    load_model();
    d0 = done_cnt;
    start_req = 1'b1;
    for (int t = 0; t < 2000 && done_cnt == d0; t++) @(negedge clk);
    check_eq("pass_done", 32'(done_cnt - d0), 32'd1);
    restart_en = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("cells_left", 32'(exp_cell.size()), 32'd0);
  endtask

  initial begin
    int d0, d, ke;
    bit found, he;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_b.start = 1'b0;
    bus_b.max_valid = 1'b1;
    #3;
    check_eq("rst_a", pack_a(), 32'd0);
    check_eq("rst_b", 32'({bus_b.en_init, bus_b.en_ins, bus_b.cell_req, bus_b.busy, bus_b.done,
                           bus_b.addr_init}), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);

    run_pass(0, 1'b0);
    run_pass(2, 1'b0);
    for (int r = 0; r < 3; r++) run_pass(1, 1'b1);

    // Abort a pass at cell (2,1) with an asynchronous reset.
    mv_mode = 0;
    restart_en = 1'b0;
    load_model();
    start_req = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge clk);
      if (bus_a.cell_req && bus_a.i == WA'(2) && bus_a.j == WA'(1)) found = 1'b1;
    end
    check_eq("reach_21", 32'(found), 32'd1);
    #1 rst_a = 1'b1;
    #1;
    check_eq("async_rst", pack_a(), 32'd0);
    running = 1'b0; armed = 1'b0; prev_req = 1'b0; prev_mv = 1'b0; prev_ins = 1'b0; req_run = 0;
    exp_init.delete();
    exp_cell.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #2 rst_a = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("no_done_rst", 32'(done_cnt - d0), 32'd0);
    run_pass(0, 1'b1);

    // Large-N instance: full init sweep with saturation.
    @(posedge clk);
    #1 bus_b.start = 1'b1;
    @(posedge clk);
    #1 bus_b.start = 1'b0;
    @(negedge clk);
    for (int n = 0; n <= 2 * NB; n++) begin
      he = (n > NB);
      ke = he ? n - NB : n;
      d = bus_b.data_init;
      check_eq("b_en_init", 32'(bus_b.en_init), 32'd1);
      check_eq("b_hit", 32'(bus_b.hit), 32'(he));
      check_eq("b_addr", 32'(bus_b.addr_init), 32'(ke));
      check_eq("b_data", 32'(d), 32'(sat_ref(ke, GB)));
      if (!he && ke == 85) check_eq("b_k85", 32'(d), 32'(-255));
      if (!he && ke == 86) check_eq("b_k86", 32'(d), 32'(-256));
      if (he && ke == NB) check_eq("b_k128", 32'(d), 32'(-256));
      @(negedge clk);
    end
    check_eq("b_init_end", 32'({bus_b.en_init, bus_b.cell_req}), 32'd1);
    check_eq("b_ij", 32'({bus_b.i, bus_b.j}), 32'd0);
    #1 rst_b = 1'b1;
    #1;
    check_eq("b_rst", 32'({bus_b.en_init, bus_b.cell_req, bus_b.busy, bus_b.done}), 32'd0);
    if (WB != 9) check_eq("b_width", 32'(WB), 32'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/score_fill_sequencer.md
Name: score_fill_sequencer

Overview:
- Control FSM that drives the score-RAM write-index stage through a full Needleman-Wunsch matrix pass.
- Phase 1 initialises row 0 and column 0 of the (N+1)x(N+1) score matrix with gap penalties, using the en_init/hit/addr_init/data_init path.
- Phase 2 sweeps the interior cells (i,j), 0..N-1 each, row-major. For each cell it requests a max from the cell-compute unit, then issues one en_ins strobe.
- Sits between the top-level control (start/done) and the write-index stage / max unit.

Parameters:
- N, 128, sequence length; matrix is (N+1)x(N+1).
- BitAddr, $clog2(N+1), index width minus one; index ports are BitAddr+1 bits.
- GAP, -2, signed gap penalty per step; fits 9-bit signed.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a pass; honoured only in IDLE
- max_valid  in  1  max unit has a result for the current (i,j)
- en_init  out  1  init write strobe to the write-index stage
- hit  out  1  0 = row-0 init (addr = k), 1 = column-0 init (addr = k*(N+1))
- addr_init  out  BitAddr+1  init index k
- data_init  out  9 signed  init score, sat(k*GAP)
- en_ins  out  1  interior write strobe
- i  out  BitAddr+1  interior row index, 0..N-1
- j  out  BitAddr+1  interior column index, 0..N-1
- cell_req  out  1  request to the max unit; i and j are valid and stable while high
- busy  out  1  pass in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: async on rst rising edge. State = IDLE; every output = 0; counters k, i, j = 0. Reset mid-pass aborts immediately, with no done pulse and no further strobes.
- All outputs are registered, decoded from registered state and counters. Clock: posedge clk.
- States: IDLE, INIT_ROW, INIT_COL, FILL_REQ, FILL_WR, DONE.
- IDLE:
  - All outputs 0.
  - start=1 -> INIT_ROW on the next edge, with k=0.
  - start is ignored in every other state.
- INIT_ROW:
  - Each cycle: en_init=1, hit=0, addr_init=k, data_init=sat(k*GAP).
  - k runs 0..N, giving N+1 cycles.
  - After k=N: go to INIT_COL with k=1.
- INIT_COL:
  - Each cycle: en_init=1, hit=1, addr_init=k, data_init=sat(k*GAP).
  - k runs 1..N, giving N cycles. Cell (0,0) is written once only, in INIT_ROW.
  - After k=N: go to FILL_REQ with i=j=0.
- FILL_REQ:
  - cell_req=1; i and j held.
  - Stay until max_valid=1 is sampled, then go to FILL_WR.
- FILL_WR:
  - Exactly one cycle of en_ins=1 with the same i,j; cell_req=0.
  - Then advance: if j<N-1, j++. Otherwise j=0 and i++.
  - After (N-1,N-1): go to DONE. Otherwise return to FILL_REQ.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- busy=1 in INIT_ROW, INIT_COL, FILL_REQ and FILL_WR; 0 in IDLE and DONE.
- Invariants:
  - en_init and en_ins are never high together.
  - When en_init=0: hit, addr_init and data_init are 0.
  - Outside FILL_REQ and FILL_WR: i and j are 0.
- max_valid is ignored outside FILL_REQ; a max_valid that is already high on entry to FILL_REQ is accepted that cycle.
- Arithmetic:
  - k*GAP is computed at full width (at least 9 + BitAddr + 1 bits, signed).
  - sat clamps to [-256, 255] before truncation to 9 bits.
- Latency:
  - Init = 2N+1 cycles.
  - Fill = at least 2 cycles per cell, i.e. at least 2N^2 for the pass.
  - start to done, with max_valid tied high: 1 + (2N+1) + 2N^2 cycles.

Test Plan:
- N=4, GAP=-2, max_valid tied 1, start pulse:
  - INIT_ROW gives addr_init 0..4, data 0,-2,-4,-6,-8, hit=0.
  - INIT_COL gives addr 1..4, data -2..-8, hit=1.
  - 16 en_ins pulses in row-major order (0,0),(0,1)..(3,3).
  - done exactly 42 cycles after start.
- N=4, max_valid delayed by 3 cycles for cell (1,2): cell_req stays high with i=1, j=2 stable for 4 cycles; single en_ins for that cell; no other cell repeated or skipped.
- N=128, GAP=-3: data_init reaches -255 at k=85 and is clamped at -256 from k=86 through k=128. No wrap to positive values.
- start re-pulsed during INIT_COL and FILL_REQ: no effect; sequence and counts unchanged.
- rst asserted during FILL_REQ at (2,1): all outputs 0 asynchronously; FSM stays IDLE with no done. A later start runs a clean full pass from k=0.
- Every cycle of all tests: assert en_init & en_ins == 0, and zeroed init fields whenever en_init=0.
